// File: rtl/demux_stripe_1x4_pkg.sv
// Shared constants and phase decode for the 1:4 byte de-striper.
// The phase triple mirrors the clock generator's {clkf,clk2f,clk4f}.
package demux_stripe_1x4_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned LANES     = 4;
  localparam int unsigned PHASE_W   = 3;
  localparam int unsigned LANE_W    = 2;

  typedef enum logic [LANE_W-1:0] {
    Lane0 = 2'd0,
    Lane1 = 2'd1,
    Lane2 = 2'd2,
    Lane3 = 2'd3
  } lane_e;

  typedef struct packed {
    logic  strobe;
    lane_e lane;
  } sample_sel_t;

  // Odd phases are sample edges; lane = (7 - phase) >> 1, which is ~phase[2:1].
  function automatic sample_sel_t phase_to_sample(input logic [PHASE_W-1:0] phase);
    sample_sel_t sel;
    sel.strobe = phase[0];
    sel.lane   = lane_e'(~phase[PHASE_W-1:1]);
    return sel;
  endfunction

endpackage

// File: rtl/demux_stripe_1x4_phase_cnt8.sv
// 3-bit down-counter in the clk8f domain; leaves reset in lockstep with the
// clock generator so its value always equals {clkf,clk2f,clk4f}.
module demux_stripe_1x4_phase_cnt8
  import demux_stripe_1x4_pkg::*;
(
  input  logic               clk8f,
  input  logic               reset,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] r_phase;

  always_ff @(posedge clk8f) begin
    if (!reset) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase - PHASE_W'(1);
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/demux_stripe_1x4.sv
// 1:4 byte de-striper: samples one byte on each odd phase and presents all
// four lanes together on the phase==1 edge, once per 8 clk8f cycles.
module demux_stripe_1x4
  import demux_stripe_1x4_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               clk8f,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               valid_in,
  output logic [WIDTH-1:0]   data_out0,
  output logic [WIDTH-1:0]   data_out1,
  output logic [WIDTH-1:0]   data_out2,
  output logic [WIDTH-1:0]   data_out3,
  output logic               valid_out0,
  output logic               valid_out1,
  output logic               valid_out2,
  output logic               valid_out3,
  output logic               frame_sync,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] w_phase;
  sample_sel_t        w_sel;
  logic [WIDTH-1:0]   w_sample_data;

  logic [WIDTH-1:0]   r_stage_data0;
  logic [WIDTH-1:0]   r_stage_data1;
  logic [WIDTH-1:0]   r_stage_data2;
  logic [2:0]         r_stage_valid;
  logic [WIDTH-1:0]   r_data_out0;
  logic [WIDTH-1:0]   r_data_out1;
  logic [WIDTH-1:0]   r_data_out2;
  logic [WIDTH-1:0]   r_data_out3;
  logic [LANES-1:0]   r_valid_out;
  logic               r_frame_sync;

  demux_stripe_1x4_phase_cnt8 u_phase_cnt8 (
    .clk8f (clk8f),
    .reset (reset),
    .phase (w_phase)
  );

  assign w_sel         = phase_to_sample(w_phase);
  assign w_sample_data = valid_in ? data_in : '0;

  // Lane3 has no staging register: it is written straight to the outputs on the
  // same edge the staged lanes are released, so the frame appears atomically.
  always_ff @(posedge clk8f) begin
    if (!reset) begin
      r_stage_data0 <= '0;
      r_stage_data1 <= '0;
      r_stage_data2 <= '0;
      r_stage_valid <= '0;
      r_data_out0   <= '0;
      r_data_out1   <= '0;
      r_data_out2   <= '0;
      r_data_out3   <= '0;
      r_valid_out   <= '0;
      r_frame_sync  <= 1'b0;
    end else begin
      r_frame_sync <= 1'b0;
      if (w_sel.strobe) begin
        unique case (w_sel.lane)
          Lane0: begin
            r_stage_data0    <= w_sample_data;
            r_stage_valid[0] <= valid_in;
          end
          Lane1: begin
            r_stage_data1    <= w_sample_data;
            r_stage_valid[1] <= valid_in;
          end
          Lane2: begin
            r_stage_data2    <= w_sample_data;
            r_stage_valid[2] <= valid_in;
          end
          Lane3: begin
            r_data_out0  <= r_stage_data0;
            r_data_out1  <= r_stage_data1;
            r_data_out2  <= r_stage_data2;
            r_data_out3  <= w_sample_data;
            r_valid_out  <= {valid_in, r_stage_valid};
            r_frame_sync <= 1'b1;
          end
        endcase
      end
    end
  end

  assign data_out0  = r_data_out0;
  assign data_out1  = r_data_out1;
  assign data_out2  = r_data_out2;
  assign data_out3  = r_data_out3;
  assign valid_out0 = r_valid_out[0];
  assign valid_out1 = r_valid_out[1];
  assign valid_out2 = r_valid_out[2];
  assign valid_out3 = r_valid_out[3];
  assign frame_sync = r_frame_sync;
  assign phase      = w_phase;

endmodule

// File: tb/tb_demux_stripe_1x4.sv
// Self-checking bench for demux_stripe_1x4: scoreboard of expected frames plus
// an independent bit-level model of the clock generator's phase triple.
module tb_demux_stripe_1x4;

  typedef struct packed {
    logic [3:0][7:0] d;
    logic [3:0]      v;
  } frame_t;

  logic       clk8f = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic       frame_sync;
  logic [2:0] phase;

  frame_t     exp_q[$];
  frame_t     m_stage, m_out, obs, e;
  logic [2:0] m_phase = 3'd0;
  logic       m_fs = 1'b0;
  logic       m_c1 = 1'b0, m_c2 = 1'b0, m_c4 = 1'b0;
  int         n_assert = 0;
  int         n_fail = 0;

  demux_stripe_1x4 #(.WIDTH(8)) dut (
    .clk8f      (clk8f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .data_out3  (data_out3),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .valid_out2 (valid_out2),
    .valid_out3 (valid_out3),
    .frame_sync (frame_sync),
    .phase      (phase)
  );

  always #5 clk8f = ~clk8f;

  assign obs = {data_out3, data_out2, data_out1, data_out0,
                valid_out3, valid_out2, valid_out1, valid_out0};

  // Drive one cycle on the falling edge, advance the model at the rising edge.
  task automatic step(input logic rst, input logic [7:0] d, input logic v);
    int lane;
    @(negedge clk8f);
    reset = rst; data_in = d; valid_in = v;
    @(posedge clk8f);
    m_fs = 1'b0;
    if (!rst) begin
      m_phase = 3'd0; m_stage = '0; m_out = '0;
      m_c1 = 1'b0; m_c2 = 1'b0; m_c4 = 1'b0;
    end else begin
      if (m_phase[0]) begin
        lane = 3 - int'(m_phase >> 1);
        m_stage.d[lane] = v ? d : 8'h00;
        m_stage.v[lane] = v;
        if (lane == 3) begin
          m_out = m_stage;
          exp_q.push_back(m_stage);
          m_fs = 1'b1;
        end
      end
      m_phase = m_phase - 3'd1;
      m_c1 = m_c1 ^ (~m_c4 & ~m_c2);
      m_c2 = m_c2 ^ ~m_c4;
      m_c4 = ~m_c4;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'hFF, 1'b1);
      n_assert++;
      if (phase !== 3'd0) begin
        n_fail++; $display("FAIL reset_phase: got %0d want 0", phase);
      end
      n_assert++;
      if (obs !== '0) begin
        n_fail++; $display("FAIL reset_outputs: got %h want 0", obs);
      end
      n_assert++;
      if (frame_sync !== 1'b0) begin
        n_fail++; $display("FAIL reset_fsync: got %b want 0", frame_sync);
      end
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) step(1'b1, b[(k - 1) / 2], 1'b1);
      else            step(1'b1, 8'h00, 1'b0);
      n_assert++;
      if (phase !== m_phase) begin
        n_fail++; $display("FAIL basic_phase: got %0d want %0d", phase, m_phase);
      end
      n_assert++;
      if (frame_sync !== m_fs) begin
        n_fail++; $display("FAIL basic_fsync k=%0d: got %b want %b", k, frame_sync, m_fs);
      end
      if (frame_sync === 1'b1) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL basic_sb: got unexpected frame %h want none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++; $display("FAIL basic_sb: got %h want %h", obs, e);
          end
        end
      end
      n_assert++;
      if (obs !== m_out) begin
        n_fail++; $display("FAIL basic_hold k=%0d: got %h want %h", k, obs, m_out);
      end
    end
    n_assert++;
    if (obs !== {8'hD4, 8'hC3, 8'hB2, 8'hA1, 4'hF}) begin
      n_fail++; $display("FAIL basic_frame: got %h want d4c3b2a1f", obs);
    end
  endtask

  task automatic test_even_noise();
    logic [7:0] b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) step(1'b1, b[(k - 1) / 2], 1'b1);
      else            step(1'b1, 8'h55, 1'b1);
      n_assert++;
      if (phase !== m_phase) begin
        n_fail++; $display("FAIL noise_phase: got %0d want %0d", phase, m_phase);
      end
      n_assert++;
      if (frame_sync !== m_fs) begin
        n_fail++; $display("FAIL noise_fsync k=%0d: got %b want %b", k, frame_sync, m_fs);
      end
      if (frame_sync === 1'b1) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL noise_sb: got unexpected frame %h want none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++; $display("FAIL noise_sb: got %h want %h", obs, e);
          end
        end
      end
      n_assert++;
      if (obs !== {8'hD4, 8'hC3, 8'hB2, 8'hA1, 4'hF}) begin
        n_fail++; $display("FAIL noise_hold k=%0d: got %h want d4c3b2a1f", k, obs);
      end
    end
  endtask

  task automatic test_invalid_lane();
    logic [7:0] b [4] = '{8'h11, 8'h77, 8'h33, 8'h44};
    logic       vv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) step(1'b1, b[(k - 1) / 2], vv[(k - 1) / 2]);
      else            step(1'b1, 8'h00, 1'b0);
      n_assert++;
      if (frame_sync !== m_fs) begin
        n_fail++; $display("FAIL inval_fsync k=%0d: got %b want %b", k, frame_sync, m_fs);
      end
      if (frame_sync === 1'b1) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL inval_sb: got unexpected frame %h want none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++; $display("FAIL inval_sb: got %h want %h", obs, e);
          end
        end
      end
    end
    n_assert++;
    if (obs !== {8'h44, 8'h33, 8'h00, 8'h11, 4'b1101}) begin
      n_fail++; $display("FAIL inval_frame: got %h want 44330011d", obs);
    end
  endtask

  task automatic test_reset_on_update();
    for (int k = 0; k < 8; k++) begin
      if (k == 7)          step(1'b0, 8'hEE, 1'b1);
      else if (k % 2 == 1) step(1'b1, 8'h90 + 8'(k), 1'b1);
      else                 step(1'b1, 8'h00, 1'b0);
    end
    n_assert++;
    if (frame_sync !== 1'b0) begin
      n_fail++; $display("FAIL rstupd_fsync: got %b want 0", frame_sync);
    end
    n_assert++;
    if (obs !== '0 || phase !== 3'd0) begin
      n_fail++; $display("FAIL rstupd_state: got %h/%0d want 0/0", obs, phase);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b [4] = '{8'h31, 8'h42, 8'h53, 8'h64};
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h11, 1'b1);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h22, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) step(1'b1, b[(k - 1) / 2], 1'b1);
      else            step(1'b1, 8'hAA, 1'b1);
      n_assert++;
      if (phase !== m_phase) begin
        n_fail++; $display("FAIL mid_phase: got %0d want %0d", phase, m_phase);
      end
      n_assert++;
      if (frame_sync !== (k == 7)) begin
        n_fail++; $display("FAIL mid_fsync k=%0d: got %b want %b", k, frame_sync, k == 7);
      end
      if (k < 7) begin
        n_assert++;
        if (obs !== '0) begin
          n_fail++; $display("FAIL mid_partial k=%0d: got %h want 0", k, obs);
        end
      end else begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL mid_sb: got frame %h want queued entry", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++; $display("FAIL mid_sb: got %h want %h", obs, e);
          end
        end
      end
    end
    n_assert++;
    if (obs !== {8'h64, 8'h53, 8'h42, 8'h31, 4'hF}) begin
      n_fail++; $display("FAIL mid_frame: got %h want 645342311f", obs);
    end
  endtask

  task automatic test_alignment();
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      n_assert++;
      if (phase !== {m_c1, m_c2, m_c4}) begin
        n_fail++; $display("FAIL align_phase i=%0d: got %0d want %0d", i, phase, {m_c1, m_c2, m_c4});
      end
      n_assert++;
      if (frame_sync !== m_fs) begin
        n_fail++; $display("FAIL align_fsync i=%0d: got %b want %b", i, frame_sync, m_fs);
      end
      if (frame_sync === 1'b1) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL align_sb: got unexpected frame %h want none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++; $display("FAIL align_sb: got %h want %h", obs, e);
          end
        end
      end
      n_assert++;
      if (obs !== m_out) begin
        n_fail++; $display("FAIL align_hold i=%0d: got %h want %h", i, obs, m_out);
      end
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d leftover want 0", exp_q.size());
    end
  endtask

  initial begin
    m_stage = '0;
    m_out   = '0;
    test_reset();
    test_basic_frame();
    test_even_noise();
    test_invalid_lane();
    test_reset_on_update();
    test_mid_reset();
    test_alignment();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
